regfile_mp_sb: RTL

//  Parametrised multi-port integer register file with a per-register busy scoreboard.

---
 rtl/regfile_mp_sb.sv | 72 +++++++
 1 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Issue marks a destination pending; writeback fills it and clears pending.
module regfile_mp_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic [NREAD*AW-1:0]     rdAddr,
    output logic [NREAD*XLEN-1:0]   rdData,
    output logic [NREAD-1:0]        rdBusy,
    input  logic [NWRITE-1:0]       wrEn,
    input  logic [NWRITE*AW-1:0]    wrAddr,
    input  logic [NWRITE*XLEN-1:0]  wrData,
    input  logic                    issueEn,
    input  logic [AW-1:0]           issueAddr,
    output logic [NREGS-1:0]        busyVec
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [AW-1:0]    addr;

    // Later write ports override earlier ones, and a same-cycle issue overrides any clear.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wrEn[j] && wrAddr[j*AW +: AW] != '0) begin
                    regs[wrAddr[j*AW +: AW]] <= wrData[j*XLEN +: XLEN];
                    busy[wrAddr[j*AW +: AW]] <= 1'b0;
                end
            end
            if (issueEn && issueAddr != '0) begin
                busy[issueAddr] <= 1'b1;
            end
        end
    end

    always_comb begin
        rdData = '0;
        rdBusy = '0;
        addr   = '0;
        for (int i = 0; i < NREAD; i++) begin
            addr = rdAddr[i*AW +: AW];
            // Register 0 and the reset window read as zero, even through the bypass.
            if (rstN && addr != '0) begin
                rdData[i*XLEN +: XLEN] = regs[addr];
                rdBusy[i]              = busy[addr];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWRITE; j++) begin
                        if (wrEn[j] && wrAddr[j*AW +: AW] == addr) begin
                            rdData[i*XLEN +: XLEN] = wrData[j*XLEN +: XLEN];
                            rdBusy[i]              = 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign busyVec = busy;

endmodule
